// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen: next-PC generator for the MIPS-subset datapath.
//
// Owns the architectural PC register. It resolves the following targets:
//   - sequential (pc+4)
//   - branch (beq/bne/bgez/bltz)
//   - j / jal
//   - jr
// It also produces the jal link value and supports stall. An illegal control
// combination or a misaligned jr target redirects the PC to an exception
// vector.
//
// Optional feature: define PC_STATS_EN to add a saturating redirect counter
// (output redirect_cnt). Without the macro, that port does not exist and
// CNT_W sizes nothing.
//
// Parameters:
//   ADDR_W    PC width in bits (30..32). All arithmetic wraps modulo 2^ADDR_W.
//   RESET_PC  PC loaded on reset (truncated to ADDR_W).
//   EXC_VEC   PC loaded on a detected control fault (truncated to ADDR_W).
//   CNT_W     redirect counter width (PC_STATS_EN only).
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   stall            hold PC and suppress every side effect this cycle
//   j, jal, jr       jump / jump-and-link / jump-register
//   br_op[2:0]       000 none, 001 beq, 010 bne, 011 bgez, 100 bltz,
//                    101..111 illegal
//   flag_zero        ALU result == 0
//   flag_neg         rs[31]
//   instr_index[25:0]  j/jal target field
//   imm16[15:0]      branch offset, in words
//   gpr_rs           jr target
//   pc               current PC (registered)
//   npc              value pc takes at the next edge when stall=0
//                    (combinational)
//   link_we          jal & ~stall & ~fault (combinational)
//   link_addr        pc+8 when jal, else 0 (combinational)
//   exc              one-cycle fault pulse (registered)
//   exc_cause        00 none, 01 conflict, 10 jr misaligned, 11 illegal br_op.
//                    Registered; holds the last cause until the next fault.
//   redirect_cnt     PC_STATS_EN only: count of non-stalled edges where
//                    npc != pc+4 (saturating)
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              j,
    input  logic              jal,
    input  logic              jr,
    input  logic [2:0]        br_op,
    input  logic              flag_zero,
    input  logic              flag_neg,
    input  logic [25:0]       instr_index,
    input  logic [15:0]       imm16,
    input  logic [ADDR_W-1:0] gpr_rs,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic              exc,
    output logic [1:0]        exc_cause
`ifdef PC_STATS_EN
    ,
    output logic [CNT_W-1:0]  redirect_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RESET_VAL = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_VAL   = EXC_VEC[ADDR_W-1:0];

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_CONFLICT = 2'b01;
    localparam logic [1:0] CAUSE_JR_ALIGN = 2'b10;
    localparam logic [1:0] CAUSE_BR_OP    = 2'b11;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] pc8;
    logic [ADDR_W-1:0] boff;
    logic [ADDR_W-1:0] jtarget;
    logic [2:0]        n_ctl;
    logic              fault;
    logic [1:0]        cause;
    logic              br_taken;

    assign pc4  = pc + ADDR_W'(4);
    assign pc8  = pc + ADDR_W'(8);
    assign boff = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

    // j/jal keep the top bits of pc+4 (the delay-slot region), not of pc.
    assign jtarget = {pc4[ADDR_W-1:28], instr_index, 2'b00};

    // Count how many control sources claim this instruction.
    // More than one of them is a conflict.
    assign n_ctl = 3'(j) + 3'(jal) + 3'(jr) + 3'(|br_op);

    // Fault detection, in priority order: conflict, illegal br_op, jr alignment.
    always_comb begin
        fault = 1'b0;
        cause = CAUSE_NONE;
        if (n_ctl > 3'd1) begin
            fault = 1'b1;
            cause = CAUSE_CONFLICT;
        end else if (br_op > 3'd4) begin
            fault = 1'b1;
            cause = CAUSE_BR_OP;
        end else if (jr && (gpr_rs[1:0] != 2'b00)) begin
            fault = 1'b1;
            cause = CAUSE_JR_ALIGN;
        end
    end

    always_comb begin
        case (br_op)
            3'b001:  br_taken = flag_zero;
            3'b010:  br_taken = ~flag_zero;
            3'b011:  br_taken = ~flag_neg;
            3'b100:  br_taken = flag_neg;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        if (fault) begin
            npc = EXC_VAL;
        end else if (br_taken) begin
            npc = pc4 + boff;
        end else if (j || jal) begin
            npc = jtarget;
        end else if (jr) begin
            npc = gpr_rs;
        end else begin
            npc = pc4;
        end
    end

    assign link_we   = jal & ~stall & ~fault;
    assign link_addr = jal ? pc8 : '0;

    // A stalled cycle leaves pc and exc_cause untouched and reports no fault.
    // That fault resurfaces when the instruction is re-presented with stall=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_VAL;
            exc       <= 1'b0;
            exc_cause <= CAUSE_NONE;
        end else if (!stall) begin
            pc  <= npc;
            exc <= fault;
            if (fault) begin
                exc_cause <= cause;
            end
        end else begin
            exc <= 1'b0;
        end
    end

`ifdef PC_STATS_EN
    // Counts any departure from straight-line flow: taken branches, jumps and
    // fault redirects. It saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
        end else if (!stall && (npc != pc4) && (redirect_cnt != {CNT_W{1'b1}})) begin
            redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end
`else
    // CNT_W is kept for a uniform parameter list; it sizes nothing here.
    if (CNT_W == 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen: self-checking bench for pc_gen (ADDR_W = 32, default vectors).
//
// Timing convention:
//   - Every task starts and ends just after a falling clock edge.
//   - Inputs are driven right after that falling edge.
//   - Combinational outputs are checked 1 time unit later.
//   - Registered outputs are checked 1 time unit after the rising edge.
//
// The reference model derives the next PC from architectural rules using
// plain integer arithmetic. Predicted PCs flow through exp_q.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        j;
    logic        jal;
    logic        jr;
    logic [2:0]  br_op;
    logic        flag_zero;
    logic        flag_neg;
    logic [25:0] instr_index;
    logic [15:0] imm16;
    logic [31:0] gpr_rs;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        link_we;
    logic [31:0] link_addr;
    logic        exc;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [1:0]  m_cause;
    logic [31:0] exp_q[$];

`ifdef PC_STATS_EN
    logic [1:0] redirect_cnt;

    pc_gen #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .j(j), .jal(jal), .jr(jr),
        .br_op(br_op), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .instr_index(instr_index), .imm16(imm16), .gpr_rs(gpr_rs),
        .pc(pc), .npc(npc), .link_we(link_we), .link_addr(link_addr),
        .exc(exc), .exc_cause(exc_cause), .redirect_cnt(redirect_cnt)
    );
`else
    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .j(j), .jal(jal), .jr(jr),
        .br_op(br_op), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .instr_index(instr_index), .imm16(imm16), .gpr_rs(gpr_rs),
        .pc(pc), .npc(npc), .link_we(link_we), .link_addr(link_addr),
        .exc(exc), .exc_cause(exc_cause)
    );
`endif

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        stall       = 1'b0;
        j           = 1'b0;
        jal         = 1'b0;
        jr          = 1'b0;
        br_op       = 3'b000;
        flag_zero   = 1'b0;
        flag_neg    = 1'b0;
        instr_index = '0;
        imm16       = '0;
        gpr_rs      = '0;
    endtask

    // Holds reset across one rising edge, then releases it on a falling edge.
    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n   = 1'b1;
        m_pc    = 32'h0000_3000;
        m_cause = 2'b00;
        exp_q.delete();
    endtask

    // One idle cycle; pc advances by 4.
    task automatic idle_cycle();
        idle_inputs();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Next PC, fault and cause from the architectural rules and current inputs.
    task automatic model_eval(output logic [31:0] e_npc, output logic e_fault,
                              output logic [1:0] e_cause);
        int   nctl;
        int   off_words;
        logic taken;

        nctl = int'(j) + int'(jal) + int'(jr) + int'(br_op != 3'd0);
        e_fault = 1'b1;
        if (nctl > 1) begin
            e_cause = 2'd1;
        end else if (br_op > 3'd4) begin
            e_cause = 2'd3;
        end else if (jr && (gpr_rs % 4 != 0)) begin
            e_cause = 2'd2;
        end else begin
            e_fault = 1'b0;
            e_cause = 2'd0;
        end

        taken = (br_op == 3'd1 &&  flag_zero) || (br_op == 3'd2 && !flag_zero) ||
                (br_op == 3'd3 && !flag_neg)  || (br_op == 3'd4 &&  flag_neg);
        off_words = int'($signed(imm16));

        if (e_fault) begin
            e_npc = 32'h0000_4180;
        end else if (taken) begin
            e_npc = m_pc + 32'd4 + 32'(off_words * 4);
        end else if (j || jal) begin
            e_npc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(instr_index) * 32'd4);
        end else if (jr) begin
            e_npc = gpr_rs;
        end else begin
            e_npc = m_pc + 32'd4;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3000) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000);
        end
        checks++;
        if (exc !== 1'b0) begin
            errors++;
            $display("FAIL reset_exc: got %b expected 0", exc);
        end
        checks++;
        if (exc_cause !== 2'b00) begin
            errors++;
            $display("FAIL reset_cause: got %b expected 00", exc_cause);
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc !== 32'h3000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 32'h3000 + 32'(4 * i));
            end
            checks++;
            if (exc !== 1'b0) begin
                errors++;
                $display("FAIL seq_exc%0d: got %b expected 0", i, exc);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
        end
        checks++;
        if (pc !== 32'h3010) begin
            errors++;
            $display("FAIL br_start_pc: got %h expected %h", pc, 32'h3010);
        end

        // beq taken, backward by 4 words.
        br_op = 3'b001;
        flag_zero = 1'b1;
        imm16 = 16'hFFFC;
        #1;
        checks++;
        if (npc !== 32'h3004) begin
            errors++;
            $display("FAIL beq_taken: got %h expected %h", npc, 32'h3004);
        end

        // beq not taken.
        flag_zero = 1'b0;
        #1;
        checks++;
        if (npc !== 32'h3014) begin
            errors++;
            $display("FAIL beq_not_taken: got %h expected %h", npc, 32'h3014);
        end
        checks++;
        if (link_we !== 1'b0 || link_addr !== 32'h0) begin
            errors++;
            $display("FAIL br_no_link: got we=%b addr=%h expected 0/0", link_we, link_addr);
        end

        // bne taken, forward by 3 words.
        br_op = 3'b010;
        imm16 = 16'h0003;
        #1;
        checks++;
        if (npc !== 32'h3020) begin
            errors++;
            $display("FAIL bne_taken: got %h expected %h", npc, 32'h3020);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3020) begin
            errors++;
            $display("FAIL bne_pc: got %h expected %h", pc, 32'h3020);
        end
        @(negedge clk);

        // bgez taken when rs is non-negative.
        br_op = 3'b011;
        flag_neg = 1'b0;
        imm16 = 16'h0010;
        #1;
        checks++;
        if (npc !== 32'h3064) begin
            errors++;
            $display("FAIL bgez_taken: got %h expected %h", npc, 32'h3064);
        end

        // bltz not taken when rs is non-negative.
        br_op = 3'b100;
        #1;
        checks++;
        if (npc !== 32'h3024) begin
            errors++;
            $display("FAIL bltz_not_taken: got %h expected %h", npc, 32'h3024);
        end
        idle_cycle();
    endtask

    task automatic test_jal_jr();
        apply_reset();
        jal = 1'b1;
        instr_index = 26'h0000D00;
        #1;
        checks++;
        if (npc !== 32'h3400) begin
            errors++;
            $display("FAIL jal_npc: got %h expected %h", npc, 32'h3400);
        end
        checks++;
        if (link_we !== 1'b1) begin
            errors++;
            $display("FAIL jal_link_we: got %b expected 1", link_we);
        end
        checks++;
        if (link_addr !== 32'h3008) begin
            errors++;
            $display("FAIL jal_link_addr: got %h expected %h", link_addr, 32'h3008);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3400) begin
            errors++;
            $display("FAIL jal_pc: got %h expected %h", pc, 32'h3400);
        end

        @(negedge clk);
        idle_inputs();
        jr = 1'b1;
        gpr_rs = 32'h3008;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3008 || exc !== 1'b0) begin
            errors++;
            $display("FAIL jr_pc: got pc=%h exc=%b expected %h/0", pc, exc, 32'h3008);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        jr = 1'b1;
        gpr_rs = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (npc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: got %h expected 0", npc);
        end

        jal = 1'b1;
        instr_index = 26'h0000001;
        #1;
        checks++;
        if (link_addr !== 32'h4) begin
            errors++;
            $display("FAIL wrap_link: got %h expected %h", link_addr, 32'h4);
        end
        checks++;
        if (npc !== 32'h4) begin
            errors++;
            $display("FAIL wrap_jal_region: got %h expected %h", npc, 32'h4);
        end

        // Advance to pc=0, then branch backwards across zero.
        idle_cycle();
        br_op = 3'b010;
        flag_zero = 1'b0;
        imm16 = 16'hFFFE;
        #1;
        checks++;
        if (npc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_branch: got %h expected %h", npc, 32'hFFFF_FFFC);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'hFFFF_FFFC || exc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_branch_pc: got pc=%h exc=%b expected fffffffc/0", pc, exc);
        end
        @(negedge clk);
    endtask

    task automatic test_faults();
        apply_reset();
        // jal+jr conflict: link suppressed, redirect to the exception vector.
        jal = 1'b1;
        jr = 1'b1;
        gpr_rs = 32'h3008;
        #1;
        checks++;
        if (npc !== 32'h4180 || link_we !== 1'b0) begin
            errors++;
            $display("FAIL conflict_comb: got npc=%h we=%b expected 4180/0", npc, link_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h4180 || exc !== 1'b1 || exc_cause !== 2'b01) begin
            errors++;
            $display("FAIL conflict_reg: got pc=%h exc=%b cause=%b expected 4180/1/01",
                     pc, exc, exc_cause);
        end
        @(negedge clk);

        idle_cycle();
        checks++;
        if (exc !== 1'b0 || exc_cause !== 2'b01 || pc !== 32'h4184) begin
            errors++;
            $display("FAIL exc_pulse_sticky: got pc=%h exc=%b cause=%b expected 4184/0/01",
                     pc, exc, exc_cause);
        end

        j = 1'b1;
        jr = 1'b1;
        gpr_rs = 32'h3000;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h4180 || exc !== 1'b1 || exc_cause !== 2'b01) begin
            errors++;
            $display("FAIL j_jr_conflict: got pc=%h exc=%b cause=%b expected 4180/1/01",
                     pc, exc, exc_cause);
        end
        @(negedge clk);

        idle_inputs();
        jr = 1'b1;
        gpr_rs = 32'h3006;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h4180 || exc !== 1'b1 || exc_cause !== 2'b10) begin
            errors++;
            $display("FAIL jr_misaligned: got pc=%h exc=%b cause=%b expected 4180/1/10",
                     pc, exc, exc_cause);
        end
        @(negedge clk);

        idle_inputs();
        br_op = 3'b110;
        @(posedge clk);
        #1;
        checks++;
        if (exc !== 1'b1 || exc_cause !== 2'b11) begin
            errors++;
            $display("FAIL illegal_br_op: got exc=%b cause=%b expected 1/11", exc, exc_cause);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1;
            jal = 1'b1;
            instr_index = 26'h0000D00;
            #1;
            checks++;
            if (link_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_link_we%0d: got %b expected 0", i, link_we);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pc !== 32'h3000 || exc !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h exc=%b expected 3000/0", i, pc, exc);
            end
            @(negedge clk);
        end

        // A fault presented under stall is not reported.
        jal = 1'b0;
        j = 1'b1;
        jr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3000 || exc !== 1'b0 || exc_cause !== 2'b00) begin
            errors++;
            $display("FAIL stall_fault: got pc=%h exc=%b cause=%b expected 3000/0/00",
                     pc, exc, exc_cause);
        end
        @(negedge clk);

        idle_inputs();
        jal = 1'b1;
        instr_index = 26'h0000D00;
        #1;
        checks++;
        if (link_we !== 1'b1) begin
            errors++;
            $display("FAIL unstall_link_we: got %b expected 1", link_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3400) begin
            errors++;
            $display("FAIL unstall_pc: got %h expected %h", pc, 32'h3400);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        // Raise a fault first so the reset has something to clear.
        j = 1'b1;
        jal = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);

        idle_inputs();
        br_op = 3'b001;
        flag_zero = 1'b1;
        imm16 = 16'h0040;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h3000 || exc !== 1'b0 || exc_cause !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got pc=%h exc=%b cause=%b expected 3000/0/00",
                     pc, exc, exc_cause);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3000) begin
            errors++;
            $display("FAIL async_reset_hold: got %h expected %h", pc, 32'h3000);
        end
        @(negedge clk);

        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3004) begin
            errors++;
            $display("FAIL post_reset_step: got %h expected %h", pc, 32'h3004);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] e_npc;
        logic        e_fault;
        logic [1:0]  e_cause;
        logic        e_stall;

        apply_reset();
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            stall       = ($urandom_range(0, 7) == 0);
            flag_zero   = 1'($urandom);
            flag_neg    = 1'($urandom);
            imm16       = 16'($urandom);
            instr_index = 26'($urandom);
            gpr_rs      = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 9))
                0, 1: ;
                2, 9: br_op = 3'($urandom_range(1, 4));
                3:    j = 1'b1;
                4:    jal = 1'b1;
                5:    jr = 1'b1;
                6: begin
                    jr = 1'b1;
                    gpr_rs = gpr_rs | 32'($urandom_range(1, 3));
                end
                7:    br_op = 3'($urandom_range(5, 7));
                default: begin
                    j = 1'($urandom);
                    jal = 1'($urandom);
                    jr = 1'($urandom);
                    br_op = 3'($urandom);
                    gpr_rs = $urandom;
                end
            endcase
            e_stall = stall;
            #1;
            model_eval(e_npc, e_fault, e_cause);
            checks++;
            if (npc !== e_npc) begin
                errors++;
                $display("FAIL rnd_npc[%0d]: got %h expected %h", n, npc, e_npc);
            end
            checks++;
            if (link_we !== (jal && !e_stall && !e_fault)) begin
                errors++;
                $display("FAIL rnd_link_we[%0d]: got %b expected %b", n, link_we,
                         jal && !e_stall && !e_fault);
            end
            checks++;
            if (link_addr !== (jal ? m_pc + 32'd8 : 32'd0)) begin
                errors++;
                $display("FAIL rnd_link_addr[%0d]: got %h expected %h", n, link_addr,
                         jal ? m_pc + 32'd8 : 32'd0);
            end
            if (!e_stall) begin
                exp_q.push_back(e_npc);
            end

            @(posedge clk);
            #1;
            if (!e_stall) begin
                m_pc = exp_q.pop_front();
                if (e_fault) begin
                    m_cause = e_cause;
                end
            end
            checks++;
            if (pc !== m_pc) begin
                errors++;
                $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc, m_pc);
            end
            checks++;
            if (exc !== (!e_stall && e_fault) || exc_cause !== m_cause) begin
                errors++;
                $display("FAIL rnd_exc[%0d]: got exc=%b cause=%b expected %b/%b", n, exc,
                         exc_cause, !e_stall && e_fault, m_cause);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

`ifdef PC_STATS_EN
    task automatic test_stats();
        int exp_cnt;

        apply_reset();
        exp_cnt = 0;
        checks++;
        if (redirect_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d expected 0", redirect_cnt);
        end

        // A not-taken branch is not a redirect.
        br_op = 3'b001;
        flag_zero = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (redirect_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stats_not_taken: got %0d expected 0", redirect_cnt);
        end
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            j = 1'b1;
            instr_index = 26'(32'h100 * (k + 1));
            @(posedge clk);
            #1;
            exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            checks++;
            if (redirect_cnt !== 2'(exp_cnt)) begin
                errors++;
                $display("FAIL stats_cnt%0d: got %0d expected %0d", k, redirect_cnt, exp_cnt);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_branch();
        test_jal_jr();
        test_wrap();
        test_faults();
        test_stall();
        test_async_reset();
        test_random();
`ifdef PC_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Sequential next-PC generator for the MIPS-subset single-cycle/multicycle datapath.
- Owns the architectural PC register.
- Resolves sequential, branch (beq/bne/bgez/bltz), j, jal and jr targets.
- Emits the jal link value, supports stall, and detects illegal control combinations and misaligned jr targets, redirecting to an exception vector.

Parameters:
- ADDR_W, 32, PC width in bits. Legal range 30..32; all arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 32'h0000_3000, PC value loaded on reset, truncated to ADDR_W.
- EXC_VEC, 32'h0000_4180, PC loaded on a detected control fault, truncated to ADDR_W.
- CNT_W, 16, width of the redirect counter. Used only with PC_STATS_EN.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, hold PC and suppress all side effects this cycle.
- j, input, 1, jump instruction.
- jal, input, 1, jump-and-link instruction.
- jr, input, 1, jump-register instruction.
- br_op, input, 3, branch type: 000 none, 001 beq, 010 bne, 011 bgez, 100 bltz; 101..111 illegal.
- flag_zero, input, 1, ALU result == 0 (rs - rt for beq/bne; rs for bgez/bltz).
- flag_neg, input, 1, rs[31] for bgez/bltz.
- instr_index, input, 26, j/jal target field.
- imm16, input, 16, branch offset in words.
- gpr_rs, input, ADDR_W, jr target.
- pc, output, ADDR_W, current PC (registered).
- npc, output, ADDR_W, combinational value PC will take at the next edge if stall=0.
- link_we, output, 1, combinational; = jal & ~stall & ~fault.
- link_addr, output, ADDR_W, combinational; pc+8 when jal, else 0.
- exc, output, 1, registered one-cycle fault pulse.
- exc_cause, output, 2, registered: 00 none, 01 conflict, 10 jr misaligned, 11 illegal br_op.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - pc = RESET_PC, exc = 0, exc_cause = 00.
  - An in-flight redirect is discarded.
  - First edge after release performs a normal update.
- pc4 = pc+4.
- boff = sign-extended imm16 shifted left 2, i.e. {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00}.
- Branch taken conditions:
  - beq: flag_zero
  - bne: ~flag_zero
  - bgez: ~flag_neg
  - bltz: flag_neg
- Fault detection, evaluated combinationally in priority order:
  - Conflict: more than one of {j, jal, jr, br_op≠000} asserted → cause 01.
  - Illegal br_op (101..111) → cause 11.
  - jr asserted with gpr_rs[1:0]≠00 → cause 10.
- npc selection, in priority order:
  - fault → EXC_VEC.
  - Taken branch → pc4 + boff.
  - j or jal → {pc4[ADDR_W-1:28], instr_index, 2'b00}. Upper slice is empty when ADDR_W=28 is excluded by the parameter range.
  - jr → gpr_rs.
  - Otherwise → pc4.
  - A not-taken branch selects pc4.
- On each rising edge with stall=0:
  - pc <= npc.
  - exc <= fault.
  - exc_cause <= fault ? cause : exc_cause, i.e. the last cause is sticky until the next fault.
- On each rising edge with stall=1:
  - pc unchanged, exc <= 0, exc_cause unchanged.
  - link_we is 0 in the same cycle.
  - Faults present during stall are not reported until the cycle they are presented with stall=0.
- Latency: control inputs affect pc one edge later; npc, link_we and link_addr are same-cycle.
- Wrap-around: pc4 at all-ones-minus-3 wraps to 0; a branch offset across 0 or 2^ADDR_W wraps silently with no fault.
- link_addr = pc+8 (delay-slot convention), wrapping likewise.

Optional Feature:
- Macro PC_STATS_EN.
- When defined:
  - Adds output redirect_cnt [CNT_W-1:0], reset to 0.
  - Increments on each non-stalled edge where npc ≠ pc4, including taken branches, jumps and faults.
  - Saturates at all-ones; never wraps.
- When undefined:
  - Port and counter are absent.
  - CNT_W is ignored.
  - All other behaviour is identical.

Test Plan:
- Reset/sequential:
  - Stimulus: rst_n low, then release; 3 idle cycles.
  - Required: pc = 0x3000, 0x3004, 0x3008, 0x300C; exc = 0.
- beq/bne:
  - Stimulus: pc=0x3010, br_op=001, flag_zero=1, imm16=0xFFFC.
  - Required: npc = 0x3004; with flag_zero=0, npc = 0x3014.
  - Stimulus: br_op=010, flag_zero=0, imm16=0x0003.
  - Required: npc = 0x3020.
- jal/jr:
  - Stimulus: pc=0x3000, jal=1, instr_index=0x0000D00.
  - Required: npc = 0x3400, link_we=1, link_addr=0x3008.
  - Stimulus: next cycle jr=1, gpr_rs=0x3008.
  - Required: pc becomes 0x3008.
- Faults:
  - Stimulus: j=1 and jr=1 together.
  - Required: pc → 0x4180, exc pulses 1 cycle, exc_cause = 01.
  - Stimulus: jr=1, gpr_rs=0x3006.
  - Required: exc_cause = 10.
  - Stimulus: br_op=110.
  - Required: exc_cause = 11.
- Stall:
  - Stimulus: jal=1 with stall=1 for 2 cycles.
  - Required: pc holds, link_we=0, exc=0; on release pc = jal target.
- Async reset mid-operation and stats:
  - Stimulus: assert rst_n low between edges during a taken branch.
  - Required: pc = 0x3000 immediately.
  - Stimulus: with PC_STATS_EN and CNT_W=2, drive 5 redirects.
  - Required: redirect_cnt = 3 (saturated).
